// File: rtl/comparator_request_scheduler_if.sv
// Requester and comparator signal bundle for the shared comparator scheduler.
// slave is the scheduler's view; master is the clients' and comparator's view.
interface comparator_request_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       cmp_a;
  logic [WIDTH-1:0]       cmp_b;
  logic                   cmp_reset;
  logic                   cmp_less;
  logic                   cmp_equal;
  logic                   cmp_greater;
  logic                   cmp_solved;
  logic [N_REQ-1:0]       rsp_valid;
  logic                   rsp_less;
  logic                   rsp_equal;
  logic                   rsp_greater;
  logic                   rsp_timeout;

  modport slave (
    input  req_valid, req_a, req_b, cmp_less, cmp_equal, cmp_greater, cmp_solved,
    output req_ready, cmp_a, cmp_b, cmp_reset,
           rsp_valid, rsp_less, rsp_equal, rsp_greater, rsp_timeout
  );

  modport master (
    output req_valid, req_a, req_b, cmp_less, cmp_equal, cmp_greater, cmp_solved,
    input  req_ready, cmp_a, cmp_b, cmp_reset,
           rsp_valid, rsp_less, rsp_equal, rsp_greater, rsp_timeout
  );
endinterface

// File: rtl/comparator_request_scheduler.sv
// Round-robin scheduler sharing one power-gated comparator among N_REQ clients.
// One transaction in flight: grant, clear comparator, wait for a settled result, respond.
module comparator_request_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                           clock,
  input  logic                           reset,
  comparator_request_scheduler_if.slave  bus,
  output logic                           busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] arb;
  logic          arb_hit;
  logic [CW-1:0] cnt;
  logic          capture;
  logic          abort;

  // First requester after the last winner, wrapping around.
  always_comb begin
    arb     = ptr;
    arb_hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!arb_hit && bus.req_valid[(int'(ptr) + i) % N_REQ]) begin
        arb_hit = 1'b1;
        arb     = PW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  // The last WAIT cycle (cnt == TIMEOUT-1) may still capture; otherwise it aborts.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:    if (arb_hit) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (cnt >= CW'(CMP_LAT) && bus.cmp_solved) begin
          capture   = 1'b1;
          state_nxt = RESPOND;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= PW'(N_REQ - 1);
      gnt             <= '0;
      cnt             <= '0;
      bus.req_ready   <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_less    <= 1'b0;
      bus.rsp_equal   <= 1'b0;
      bus.rsp_greater <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.cmp_a       <= '0;
      bus.cmp_b       <= '0;
    end else begin
      state         <= state_nxt;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (arb_hit) begin
            bus.req_ready[arb] <= 1'b1;
            gnt                <= arb;
            bus.cmp_a          <= bus.req_a[arb*WIDTH +: WIDTH];
            bus.cmp_b          <= bus.req_b[arb*WIDTH +: WIDTH];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (capture) begin
            bus.rsp_valid[gnt] <= 1'b1;
            bus.rsp_less       <= bus.cmp_less;
            bus.rsp_equal      <= bus.cmp_equal;
            bus.rsp_greater    <= bus.cmp_greater;
            bus.rsp_timeout    <= 1'b0;
          end else if (abort) begin
            bus.rsp_valid[gnt] <= 1'b1;
            bus.rsp_less       <= 1'b0;
            bus.rsp_equal      <= 1'b0;
            bus.rsp_greater    <= 1'b0;
            bus.rsp_timeout    <= 1'b1;
          end
        end
        RESPOND: ptr <= gnt;
        default: ;
      endcase
    end
  end

  // The comparator is only released from reset while a result is awaited.
  assign bus.cmp_reset = (state != WAIT);
  assign busy          = (state != IDLE);
endmodule

// File: doc/comparator_request_scheduler.md
Name: comparator_request_scheduler

Overview:
- Shares one Multi_Bit_Comparator_PowerGated instance among N_REQ requesters using round-robin arbitration.
- Accepts an operand pair from one requester, clears and drives the comparator, waits for a settled result, and returns it one-hot to the winner.
- Sits between client logic and the comparator datapath; owns the comparator's operand, reset and result sampling.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits; equals comparator n+1.
- CMP_LAT, 2, minimum cycles after issue before cmp_solved is trusted (input register plus ripple).
- TIMEOUT, 15, maximum WAIT cycles before abort; must be greater than CMP_LAT.

Ports:
- clock  in  1  system clock; also clocks the comparator's input register.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request; held until granted.
- req_a  in  N_REQ*WIDTH  operand A; requester k uses bits [k*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  N_REQ  one-hot, one-cycle accept pulse.
- cmp_a  out  WIDTH  operand A to comparator a_in.
- cmp_b  out  WIDTH  operand B to comparator b_in.
- cmp_reset  out  1  comparator reset, active-high.
- cmp_less  in  1  comparator less_than.
- cmp_equal  in  1  comparator equal_to.
- cmp_greater  in  1  comparator greater_than.
- cmp_solved  in  1  comparator solved.
- rsp_valid  out  N_REQ  one-hot, one-cycle result strobe to the granted requester.
- rsp_less  out  1  result flag, valid with rsp_valid.
- rsp_equal  out  1  result flag, valid with rsp_valid.
- rsp_greater  out  1  result flag, valid with rsp_valid.
- rsp_timeout  out  1  set with rsp_valid when the result was aborted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, any state):
  - State goes to IDLE.
  - Outputs: req_ready=0, rsp_valid=0, rsp flags=0, rsp_timeout=0, cmp_a=cmp_b=0, cmp_reset=1, busy=0.
  - Round-robin pointer ptr is set to N_REQ-1, so requester 0 has first priority.
  - An in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - cmp_reset=1, which keeps the comparator gated.
  - If any req_valid is high, grant g = first set index scanning ptr+1, ptr+2, … modulo N_REQ.
  - Registered outputs: req_ready[g]=1 for exactly the next cycle; cmp_a/cmp_b latch req_a/req_b slice g; state goes to ISSUE.
  - The handshake completes on the req_ready pulse. The requester may drop req_valid or present new operands in the cycle after the pulse.
- ISSUE (1 cycle):
  - cmp_reset=1 to clear stale outputs; operands are held.
  - Wait counter is cleared to 0; state goes to WAIT.
- WAIT:
  - cmp_reset=0; operands are held stable; counter increments each cycle.
  - Result capture: when counter >= CMP_LAT and cmp_solved=1, capture the less/equal/greater flags, clear rsp_timeout, and go to RESPOND.
  - Abort: if counter reaches TIMEOUT without capture, all result flags=0, rsp_timeout=1, go to RESPOND.
  - If capture and timeout coincide, capture wins.
- RESPOND (1 cycle):
  - rsp_valid[g]=1 and flags are driven; ptr <= g; cmp_reset=1; go to IDLE.
  - Flags hold their last value until the next RESPOND. Consumers must qualify them with rsp_valid.
- Latency:
  - Accept edge at cycle T; req_ready is visible in T+1 (ISSUE); WAIT starts at T+2.
  - Earliest rsp_valid is cycle T+2+CMP_LAT+1.
- Throughput:
  - A new grant can occur in the IDLE cycle following RESPOND.
  - At most one transaction is in flight.
- Fairness: a continuously requesting client waits at most N_REQ-1 transactions.
- req_valid and operands are sampled only in IDLE; changes in other states are ignored.
- Exactly one result flag is expected when solved. The scheduler passes flags through unchanged and does not check them.

Test Plan:
- Single request: reset, then req_valid[2]=1 with A=4'b1010, B=4'b0110. Expect req_ready[2] pulse, then rsp_valid[2] with greater=1, less=0, equal=0, busy=0 afterwards.
- Equal operands: requester 0 sends A=B=4'hF. Expect rsp_equal=1 and rsp_valid=4'b0001 at exactly T+2+CMP_LAT+1.
- Round-robin: all four req_valid held high with distinct operands. Grant order is 0,1,2,3,0; each rsp_valid matches the granted index and carries the correct flags for its operands.
- Timeout: model holds cmp_solved=0. Expect rsp_valid after TIMEOUT WAIT cycles with rsp_timeout=1 and all flags 0; the next request completes normally.
- Early-solved masking: model asserts cmp_solved=1 with stale less=1 during the first WAIT cycle. That value is ignored until counter=CMP_LAT, and the correct result is captured.
- Mid-operation reset: assert reset during WAIT. Next cycle is IDLE with cmp_reset=1, busy=0, no rsp_valid; requester 0 wins the following arbitration.
